// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial line in, SIPO drive and frame status out.
// The slave side is the bit-timing controller; the master side is the line
// driver / frame consumer.
interface uart_rx_ctrl_if;
    logic rx;
    logic rx_bit;
    logic sample_done;
    logic shift;
    logic frame_done;
    logic frame_err;
    logic busy;

    modport slave (
        input  rx,
        output rx_bit,
        output sample_done,
        output shift,
        output frame_done,
        output frame_err,
        output busy
    );

    modport master (
        output rx,
        input  rx_bit,
        input  sample_done,
        input  shift,
        input  frame_done,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive bit-timing controller.
// Synchronises rx, qualifies the start bit, strobes mid-bit samples into the
// external SIPO and reports frame completion / stop-bit errors.
// Optional build macro RX_MAJORITY_EN: 2-of-3 vote around each sample point,
// with every strobe one clock later than the single-sample build.
module uart_rx_ctrl #(
    parameter  int CLKS_PER_BIT = 16,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             reset,
    uart_rx_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE,
        WAIT_HIGH
    } state_t;

    localparam logic [CNT_W-1:0] LAST_PT = CNT_W'(CLKS_PER_BIT - 1);
`ifdef RX_MAJORITY_EN
    // Decision lands on the third vote, one clock past the nominal centre.
    localparam logic [CNT_W-1:0] START_PT = CNT_W'(CLKS_PER_BIT / 2);
`else
    localparam logic [CNT_W-1:0] START_PT = CNT_W'(CLKS_PER_BIT / 2 - 1);
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       sync_q, sync_d;
    logic             rx_prev_q, rx_prev_d;
    logic             rx_bit_q, rx_bit_d;
    logic             stop_q, stop_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_sync;
    logic             fall;
    logic             sample_val;
    logic             strobe;

    assign rx_sync = sync_q[1];
    assign fall    = rx_prev_q & ~rx_sync;

`ifdef RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    // Two previous synchronised samples feed the vote with the current one.
    always_comb begin
        hist_d = {hist_q[0], rx_sync};
    end

    // Vote history register; idle-high after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hist_q <= 2'b11;
        else        hist_q <= hist_d;
    end

    assign sample_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_sync) |
                        (hist_q[0] & rx_sync);
`else
    assign sample_val = rx_sync;
`endif

    // Synchroniser chain and falling-edge reference for the line.
    always_comb begin
        sync_d    = {sync_q[0], bus.rx};
        rx_prev_d = rx_sync;
    end

    // Bit-timing FSM: next state, counters, strobe and frame status.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        stop_d       = stop_q;
        strobe       = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == START_PT) begin
                    cnt_d = '0;
                    if (!sample_val) begin
                        strobe    = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_PT) begin
                    strobe    = 1'b1;
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_PT) begin
                    strobe       = 1'b1;
                    cnt_d        = '0;
                    stop_d       = sample_val;
                    frame_done_d = 1'b1;
                    frame_err_d  = ~sample_val;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = stop_q ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                // A held-low line (break) must go high before re-arming.
                if (rx_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rx_bit_d = strobe ? sample_val : rx_bit_q;
    end

    // State, counters, synchroniser and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= 4'd0;
            sync_q       <= 2'b11;
            rx_prev_q    <= 1'b1;
            rx_bit_q     <= 1'b1;
            stop_q       <= 1'b1;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            sync_q       <= sync_d;
            rx_prev_q    <= rx_prev_d;
            rx_bit_q     <= rx_bit_d;
            stop_q       <= stop_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.rx_bit      = rx_bit_d;
    assign bus.sample_done = strobe;
    assign bus.shift       = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign bus.busy        = (state_q != IDLE);
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: drives serial frames at 16 clocks per bit,
// models the receive SIPO and scores each completed frame against a queue
// of expected frames.
module tb_uart_rx_ctrl;

    typedef struct {
        logic [9:0] frame;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   frame_strobes = 0;
    int   last_strobe_cyc = 0;
    int   strobe_total = 0;
    logic [9:0] sipo;
    exp_t sb[$];
    int   fd_cyc[$];
    logic bits_seen[$];

    uart_rx_ctrl_if bus();

    uart_rx_ctrl #(.CLKS_PER_BIT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference SIPO: shifts right so the start bit ends in bit 0.
    always @(posedge clk or negedge reset) begin
        if (!reset)               sipo <= 10'd0;
        else if (bus.sample_done) sipo <= {bus.rx_bit, sipo[9:1]};
    end

    // Monitor / scoreboard, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                frame_strobes = 0;
            end else begin
                if (bus.sample_done === 1'b1) begin
                    strobe_total++;
                    bits_seen.push_back(bus.rx_bit);
                    if (frame_strobes > 0) begin
                        total++;
                        if ((cyc - last_strobe_cyc) !== 16) begin
                            bad++;
                            $display("FAIL strobe_spacing got=%0d want=16", cyc - last_strobe_cyc);
                        end
                    end
                    frame_strobes++;
                    last_strobe_cyc = cyc;
                end
                if (bus.frame_done === 1'b1) begin
                    fd_cyc.push_back(cyc);
                    total++;
                    if (frame_strobes !== 10) begin
                        bad++;
                        $display("FAIL strobe_count got=%0d want=10", frame_strobes);
                    end
                    frame_strobes = 0;
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_frame_done got=frame_done want=none");
                    end else begin
                        e = sb.pop_front();
                        total++;
                        if (sipo !== e.frame) begin
                            bad++;
                            $display("FAIL sipo_frame got=%b want=%b", sipo, e.frame);
                        end
                        total++;
                        if (bus.frame_err !== e.err) begin
                            bad++;
                            $display("FAIL frame_err got=%b want=%b", bus.frame_err, e.err);
                        end
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] data, input logic stop);
        exp_t e;
        e.frame = {stop, data, 1'b0};
        e.err   = ~stop;
        sb.push_back(e);
    endtask

    // Sends start, 8 data bits LSB first and stop; starts and ends on a negedge.
    // glitch_bit >= 0 inverts that bit for one clock at its centre.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_bit);
        logic val;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      val = 1'b0;
            else if (k == 9) val = stop;
            else             val = data[k-1];
            bus.rx = val;
            if (k == glitch_bit) begin
                repeat (8) @(negedge clk);
                bus.rx = ~val;
                @(negedge clk);
                bus.rx = val;
                repeat (7) @(negedge clk);
            end else begin
                repeat (16) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.rx_bit !== 1'b1)      begin bad++; $display("FAIL reset_rx_bit got=%b want=1", bus.rx_bit); end
        total++; if (bus.sample_done !== 1'b0) begin bad++; $display("FAIL reset_sample_done got=%b want=0", bus.sample_done); end
        total++; if (bus.shift !== 1'b0)       begin bad++; $display("FAIL reset_shift got=%b want=0", bus.shift); end
        total++; if (bus.frame_done !== 1'b0)  begin bad++; $display("FAIL reset_frame_done got=%b want=0", bus.frame_done); end
        total++; if (bus.frame_err !== 1'b0)   begin bad++; $display("FAIL reset_frame_err got=%b want=0", bus.frame_err); end
        total++; if (bus.busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        reset = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bits_seen.delete();
        push_exp(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1, -1);
        bus.rx = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL basic_frame_done got_pending=%0d want=0", sb.size()); end
        total++;
        if (bits_seen.size() !== 10) begin
            bad++; $display("FAIL basic_bit_count got=%0d want=10", bits_seen.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (bits_seen[i] !== exp_bits[i]) begin
                    bad++; $display("FAIL basic_rx_bit[%0d] got=%b want=%b", i, bits_seen[i], exp_bits[i]);
                end
            end
        end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", bus.busy); end
    endtask

    task automatic test_false_start();
        int st0 = strobe_total;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL false_start_detect got=%b want=1", bus.busy); end
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (strobe_total !== st0) begin bad++; $display("FAIL false_start_strobes got=%0d want=%0d", strobe_total, st0); end
        total++;
        if (bus.shift !== 1'b0) begin bad++; $display("FAIL false_start_shift got=%b want=0", bus.shift); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL false_start_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_stop_error();
        int st0 = strobe_total;
        push_exp(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0, -1);
        repeat (40) @(negedge clk);
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL stop_err_frame_done got_pending=%0d want=0", sb.size()); end
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL stop_err_busy_held got=%b want=1", bus.busy); end
        total++;
        if (bus.shift !== 1'b0) begin bad++; $display("FAIL stop_err_shift got=%b want=0", bus.shift); end
        total++;
        if (strobe_total !== st0 + 10) begin bad++; $display("FAIL stop_err_no_retrigger got=%0d want=%0d", strobe_total, st0 + 10); end
        bus.rx = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL stop_err_release got=%b want=0", bus.busy); end
    endtask

    task automatic test_reset_midframe();
        int fd0 = fd_cyc.size();
        // start, d0..d2 of 0x5A, then half of d3
        bus.rx = 1'b0; repeat (16) @(negedge clk);
        bus.rx = 1'b0; repeat (16) @(negedge clk);
        bus.rx = 1'b1; repeat (16) @(negedge clk);
        bus.rx = 1'b0; repeat (16) @(negedge clk);
        bus.rx = 1'b1; repeat (8)  @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL midframe_busy_before got=%b want=1", bus.busy); end
        #2 reset = 1'b0;
        #1;
        total++; if (bus.rx_bit !== 1'b1)      begin bad++; $display("FAIL abort_rx_bit got=%b want=1", bus.rx_bit); end
        total++; if (bus.sample_done !== 1'b0) begin bad++; $display("FAIL abort_sample_done got=%b want=0", bus.sample_done); end
        total++; if (bus.shift !== 1'b0)       begin bad++; $display("FAIL abort_shift got=%b want=0", bus.shift); end
        total++; if (bus.frame_done !== 1'b0)  begin bad++; $display("FAIL abort_frame_done got=%b want=0", bus.frame_done); end
        total++; if (bus.frame_err !== 1'b0)   begin bad++; $display("FAIL abort_frame_err got=%b want=0", bus.frame_err); end
        total++; if (bus.busy !== 1'b0)        begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
        @(negedge clk);
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (fd_cyc.size() !== fd0) begin bad++; $display("FAIL abort_no_frame_done got=%0d want=%0d", fd_cyc.size(), fd0); end
        push_exp(8'h5A, 1'b1);
        send_frame(8'h5A, 1'b1, -1);
        bus.rx = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL after_abort_frame got_pending=%0d want=0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int n0 = fd_cyc.size();
        push_exp(8'h00, 1'b1);
        push_exp(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        bus.rx = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (fd_cyc.size() !== n0 + 2) begin
            bad++; $display("FAIL b2b_frame_count got=%0d want=%0d", fd_cyc.size() - n0, 2);
        end else begin
            total++;
            if ((fd_cyc[n0+1] - fd_cyc[n0]) !== 160) begin
                bad++; $display("FAIL b2b_spacing got=%0d want=160", fd_cyc[n0+1] - fd_cyc[n0]);
            end
        end
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL b2b_pending got=%0d want=0", sb.size()); end
    endtask

    task automatic test_glitch();
`ifdef RX_MAJORITY_EN
        push_exp(8'h00, 1'b1);
`else
        push_exp(8'h04, 1'b1);
`endif
        // frame bit index 3 is data bit 2
        send_frame(8'h00, 1'b1, 3);
        bus.rx = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL glitch_frame got_pending=%0d want=0", sb.size()); end
    endtask

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_basic_frame();
        test_false_start();
        test_stop_error();
        test_reset_midframe();
        test_back_to_back();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
